// File: rtl/lsu_align_unit.sv
// lsu_align_unit: maps b/h/w loads/stores at any byte address onto word-only DataMemory (req/resp handshake, mem_* side)
module lsu_align_unit #(
  parameter logic ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_access_addr,
  output logic [31:0] mem_in,
  output logic        mem_write_en,
  output logic        mem_read_en,
  output logic [2:0]  mem_data_size,
  input  logic [31:0] mem_out
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD0  = 3'd1;
  localparam logic [2:0] RD1  = 3'd2;
  localparam logic [2:0] WR0  = 3'd3;
  localparam logic [2:0] WR1  = 3'd4;
  localparam logic [2:0] RESP = 3'd5;
  logic [2:0]  state, state_nx;
  logic [31:0] addr_r, wdata_r, lo, hi;
  logic [2:0]  size_r;
  logic        write_r, err_r;
  logic        req_bad_size, req_mis, req_err, req_sw_aligned;
  logic [1:0]  off, nb_m1;
  logic [2:0]  last_byte;
  logic        span, sx;
  logic [4:0]  sh;
  logic [31:0] a0, a1, rd_w, ext;
  logic [63:0] bmask, mask, wide, merged;
  assign req_bad_size   = req_size == 3'b011 || req_size[2:1] == 2'b11;
  assign req_mis        = (req_size[1:0] == 2'b01 && req_addr[0]) || (req_size[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
  assign req_err        = req_bad_size || (req_write && req_size[2]) || (!ALLOW_MISALIGNED && req_mis);
  assign req_sw_aligned = req_write && req_size == 3'b010 && req_addr[1:0] == 2'b00;
  assign off       = addr_r[1:0];
  assign nb_m1     = size_r[1:0] == 2'b00 ? 2'd0 : size_r[1:0] == 2'b01 ? 2'd1 : 2'd3;
  assign last_byte = {1'b0, off} + {1'b0, nb_m1};
  assign span      = last_byte[2];
  assign sx        = !size_r[2];
  assign sh        = {off, 3'b000};
  assign a0        = {addr_r[31:2], 2'b00};
  assign a1        = a0 + 32'd4;
  // {hi,lo} is the 8-byte window starting at A0; stores and loads are byte-lane shifts within it
  assign bmask     = size_r[1:0] == 2'b00 ? 64'hFF : size_r[1:0] == 2'b01 ? 64'hFFFF : 64'hFFFF_FFFF;
  assign mask      = bmask << sh;
  assign wide      = {32'b0, wdata_r} << sh;
  assign merged    = ({hi, lo} & ~mask) | (wide & mask);
  assign rd_w      = 32'({hi, lo} >> sh);
  assign ext       = size_r[1:0] == 2'b00 ? {{24{sx & rd_w[7]}}, rd_w[7:0]} :
                     size_r[1:0] == 2'b01 ? {{16{sx & rd_w[15]}}, rd_w[15:0]} : rd_w;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:    state_nx = !req_valid ? IDLE : req_err ? RESP : req_sw_aligned ? WR0 : RD0;
      RD0:     state_nx = span ? RD1 : write_r ? WR0 : RESP;
      RD1:     state_nx = write_r ? WR0 : RESP;
      WR0:     state_nx = span ? WR1 : RESP;
      WR1:     state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_r  <= '0;
      wdata_r <= '0;
      size_r  <= '0;
      write_r <= 1'b0;
      err_r   <= 1'b0;
      lo      <= '0;
      hi      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        size_r  <= req_size;
        write_r <= req_write;
        err_r   <= req_err;
      end
      if (state == RD0) lo <= mem_out;
      if (state == RD1) hi <= mem_out;
    end
  end
  assign req_ready       = state == IDLE;
  assign resp_valid      = state == RESP;
  assign resp_err        = resp_valid && err_r;
  assign resp_rdata      = (resp_valid && !err_r && !write_r) ? ext : 32'h0;
  assign mem_read_en     = state == RD0 || state == RD1;
  // a reset edge must never commit a write
  assign mem_write_en    = (state == WR0 || state == WR1) && !rst;
  assign mem_access_addr = (state == RD0 || state == WR0) ? a0 : (state == RD1 || state == WR1) ? a1 : 32'h0;
  assign mem_in          = state == WR0 ? merged[31:0] : state == WR1 ? merged[63:32] : 32'h0;
  assign mem_data_size   = 3'b010;
endmodule
